// File: rtl/axi_outstanding_regulator_if.sv
// Address-channel handshakes and B/R completion monitors seen by the outstanding regulator.
interface axi_outstanding_regulator_if;
  logic       s_awvalid;
  logic       s_awready;
  logic [7:0] s_awlen;
  logic       m_awvalid;
  logic       m_awready;
  logic       s_arvalid;
  logic       s_arready;
  logic [7:0] s_arlen;
  logic       m_arvalid;
  logic       m_arready;
  logic       bvalid;
  logic       bready;
  logic       rvalid;
  logic       rready;
  logic       rlast;

  modport slave (
    input  s_awvalid, s_awlen, m_awready,
    input  s_arvalid, s_arlen, m_arready,
    input  bvalid, bready, rvalid, rready, rlast,
    output s_awready, m_awvalid, s_arready, m_arvalid
  );

  modport master (
    output s_awvalid, s_awlen, m_awready,
    output s_arvalid, s_arlen, m_arready,
    output bvalid, bready, rvalid, rready, rlast,
    input  s_awready, m_awvalid, s_arready, m_arvalid
  );
endinterface

// File: rtl/axi_outstanding_regulator.sv
// Per-master AXI guard: caps outstanding AW/AR bursts and beats admitted per window.
// Optional stall statistics counter is built when AXI_REG_STATS_EN is defined.
module axi_outstanding_regulator #(
  parameter int MAX_WR_OUT  = 16,
  parameter int MAX_RD_OUT  = 16,
  parameter int WINDOW      = 1024,
  parameter int BEAT_BUDGET = 512
) (
  input  logic                        clk_100MHz,
  input  logic                        reset_rtl_0,
  input  logic                        cfg_enable,
  axi_outstanding_regulator_if.slave  bus,
  output logic                        throttle_active,
  output logic                        err_underflow,
  output logic [31:0]                 stall_cycles
);
  localparam int WIN_W = $clog2(WINDOW);

  typedef enum logic [1:0] {
    ST_BYPASS    = 2'd0,
    ST_OPEN      = 2'd1,
    ST_THROTTLED = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [7:0]         wr_cnt_r, rd_cnt_r, wr_cnt_next_s, rd_cnt_next_s;
  logic [WIN_W-1:0]   win_cnt_r;
  logic [15:0]        beats_left_r, beats_left_next_s;
  logic [16:0]        beats_base_s;
  logic [9:0]         charge_s;
  logic               throttle_r, err_r;
  logic               aw_allow_s, ar_allow_s, wrap_s;
  logic               aw_hs_s, ar_hs_s, b_hs_s, rl_hs_s;

  // Counter saturates at both ends; simultaneous inc/dec cancel out.
  function automatic logic [7:0] cnt_update(input logic [7:0] cnt, input logic inc, input logic dec);
    logic [7:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end else if (dec && !inc) begin
      res = (cnt == 8'd0) ? cnt : cnt - 8'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  assign aw_allow_s = (state_r != ST_THROTTLED) && ((state_r == ST_BYPASS) || (wr_cnt_r < 8'(MAX_WR_OUT)));
  assign ar_allow_s = (state_r != ST_THROTTLED) && ((state_r == ST_BYPASS) || (rd_cnt_r < 8'(MAX_RD_OUT)));

  assign bus.m_awvalid = bus.s_awvalid & aw_allow_s;
  assign bus.s_awready = bus.m_awready & aw_allow_s;
  assign bus.m_arvalid = bus.s_arvalid & ar_allow_s;
  assign bus.s_arready = bus.m_arready & ar_allow_s;

  assign aw_hs_s = bus.m_awvalid & bus.m_awready;
  assign ar_hs_s = bus.m_arvalid & bus.m_arready;
  assign b_hs_s  = bus.bvalid & bus.bready;
  assign rl_hs_s = bus.rvalid & bus.rready & bus.rlast;

  assign wrap_s        = (win_cnt_r == WIN_W'(WINDOW - 1));
  assign wr_cnt_next_s = cnt_update(wr_cnt_r, aw_hs_s, b_hs_s);
  assign rd_cnt_next_s = cnt_update(rd_cnt_r, ar_hs_s, rl_hs_s);

  // Beat charge for this cycle and the budget remaining after it (refill on wrap).
  always_comb begin
    charge_s = (aw_hs_s ? ({2'b00, bus.s_awlen} + 10'd1) : 10'd0)
             + (ar_hs_s ? ({2'b00, bus.s_arlen} + 10'd1) : 10'd0);
    beats_base_s = wrap_s ? 17'(BEAT_BUDGET) : {1'b0, beats_left_r};
    if (beats_base_s > {7'd0, charge_s}) begin
      beats_left_next_s = 16'(beats_base_s - {7'd0, charge_s});
    end else begin
      beats_left_next_s = 16'd0;
    end
  end

  // Regulation state transitions; disabling always wins.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_BYPASS: begin
        if (cfg_enable) state_next_s = ST_OPEN;
        else            state_next_s = ST_BYPASS;
      end
      ST_OPEN: begin
        if (!cfg_enable)                      state_next_s = ST_BYPASS;
        else if (beats_left_next_s == 16'd0)  state_next_s = ST_THROTTLED;
        else                                  state_next_s = ST_OPEN;
      end
      ST_THROTTLED: begin
        if (!cfg_enable) state_next_s = ST_BYPASS;
        else if (wrap_s) state_next_s = ST_OPEN;
        else             state_next_s = ST_THROTTLED;
      end
      default: state_next_s = ST_BYPASS;
    endcase
  end

  // State, counters, budget and sticky status registers.
  always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_r      <= ST_BYPASS;
      wr_cnt_r     <= 8'd0;
      rd_cnt_r     <= 8'd0;
      win_cnt_r    <= '0;
      beats_left_r <= 16'(BEAT_BUDGET);
      throttle_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wr_cnt_r     <= wr_cnt_next_s;
      rd_cnt_r     <= rd_cnt_next_s;
      win_cnt_r    <= wrap_s ? '0 : win_cnt_r + WIN_W'(1);
      beats_left_r <= beats_left_next_s;
      throttle_r   <= (state_next_s == ST_THROTTLED);
      err_r        <= err_r | (b_hs_s && (wr_cnt_r == 8'd0)) | (rl_hs_s && (rd_cnt_r == 8'd0));
    end
  end

  assign throttle_active = throttle_r;
  assign err_underflow   = err_r;

`ifdef AXI_REG_STATS_EN
  logic        stall_s;
  logic [31:0] stall_r;

  assign stall_s = (bus.s_awvalid & ~aw_allow_s) | (bus.s_arvalid & ~ar_allow_s);

  // Saturating count of cycles where a request is held off.
  always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      stall_r <= 32'd0;
    end else if (stall_s && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cycles = stall_r;
`else
  assign stall_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_axi_outstanding_regulator.sv
// Directed bench for axi_outstanding_regulator: vector table plus multi-cycle corner sequences.
module tb_axi_outstanding_regulator;
  logic        clk_100MHz = 1'b0;
  logic        reset_rtl_0;
  logic        cfg_enable;
  logic        throttle_active;
  logic        err_underflow;
  logic [31:0] stall_cycles;
  int          n_checks = 0;
  int          n_errors = 0;

  axi_outstanding_regulator_if bus ();

  axi_outstanding_regulator dut (
    .clk_100MHz      (clk_100MHz),
    .reset_rtl_0     (reset_rtl_0),
    .cfg_enable      (cfg_enable),
    .bus             (bus.slave),
    .throttle_active (throttle_active),
    .err_underflow   (err_underflow),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk_100MHz = ~clk_100MHz;

`ifdef AXI_REG_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd100;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  typedef struct {
    logic       cfg;
    logic       awv;
    logic [7:0] awlen;
    logic       awrdy;
    logic       arv;
    logic [7:0] arlen;
    logic       arrdy;
    logic       b;
    logic       rl;
    logic       e_maw;
    logic       e_saw;
    logic       e_mar;
    logic       e_sar;
    logic [7:0] e_wr;
    logic [7:0] e_rd;
    logic [15:0] e_beats;
    logic       e_thr;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.s_awvalid = 1'b0; bus.s_awlen = 8'd0; bus.m_awready = 1'b0;
    bus.s_arvalid = 1'b0; bus.s_arlen = 8'd0; bus.m_arready = 1'b0;
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    cfg_enable  = 1'b0;
    reset_rtl_0 = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset_rtl_0 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // cfg awv len rdy arv len rdy b rl | maw saw mar sar wr rd beats thr
    vecs[0]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'd512, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'd255, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 16'd256, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 8'd239, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 16'd16,  1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'd2,   1'b1, 1'b1, 8'd2,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 16'd10,  1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'd3,   1'b1, 1'b1, 8'd7,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 8'd3, 16'd0,   1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'd0,   1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 16'd0,   1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 16'd0,   1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 16'd0,   1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2, 16'd0,   1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 16'd0,   1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 16'd0,   1'b1};

    // Reset state
    do_reset();
    chk("rst_throttle", {31'd0, throttle_active}, 32'd0);
    chk("rst_err", {31'd0, err_underflow}, 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_beats", {16'd0, dut.beats_left_r}, 32'd512);
    chk("rst_wr", {24'd0, dut.wr_cnt_r}, 32'd0);

    // Vector table: budget drain to zero, same-cycle AW+AR, coincident AW+B, bypass
    for (int i = 0; i < 11; i++) begin
      cfg_enable    = vecs[i].cfg;
      bus.s_awvalid = vecs[i].awv; bus.s_awlen = vecs[i].awlen; bus.m_awready = vecs[i].awrdy;
      bus.s_arvalid = vecs[i].arv; bus.s_arlen = vecs[i].arlen; bus.m_arready = vecs[i].arrdy;
      bus.bvalid = vecs[i].b; bus.bready = vecs[i].b;
      bus.rvalid = vecs[i].rl; bus.rready = vecs[i].rl; bus.rlast = vecs[i].rl;
      #1;
      chk($sformatf("v%0d_m_awvalid", i), {31'd0, bus.m_awvalid}, {31'd0, vecs[i].e_maw});
      chk($sformatf("v%0d_s_awready", i), {31'd0, bus.s_awready}, {31'd0, vecs[i].e_saw});
      chk($sformatf("v%0d_m_arvalid", i), {31'd0, bus.m_arvalid}, {31'd0, vecs[i].e_mar});
      chk($sformatf("v%0d_s_arready", i), {31'd0, bus.s_arready}, {31'd0, vecs[i].e_sar});
      tick();
      chk($sformatf("v%0d_wr_cnt", i), {24'd0, dut.wr_cnt_r}, {24'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_rd_cnt", i), {24'd0, dut.rd_cnt_r}, {24'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_beats", i), {16'd0, dut.beats_left_r}, {16'd0, vecs[i].e_beats});
      chk($sformatf("v%0d_throttle", i), {31'd0, throttle_active}, {31'd0, vecs[i].e_thr});
    end
    chk("v_err_clean", {31'd0, err_underflow}, 32'd0);

    // T1: bypass lets 40 bursts through regardless of limits
    do_reset();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      bus.s_awvalid = 1'b1; bus.s_awlen = 8'd127; bus.m_awready = 1'b1;
      #1;
      if (bus.s_awready && bus.m_awvalid) acc++;
      tick();
    end
    clear_inputs();
    chk("t1_accepted", acc, 32'd40);
    chk("t1_wr_cnt", {24'd0, dut.wr_cnt_r}, 32'd40);
    chk("t1_stall", stall_cycles, 32'd0);
    chk("t1_throttle", {31'd0, throttle_active}, 32'd0);

    // T2: outstanding write cap, one B frees exactly one slot
    do_reset();
    cfg_enable = 1'b1;
    tick();
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      bus.s_awvalid = 1'b1; bus.s_awlen = 8'd0; bus.m_awready = 1'b1;
      #1;
      if (!bus.s_awready) break;
      acc++;
      tick();
    end
    chk("t2_accepted", acc, 32'd16);
    chk("t2_blocked_ready", {31'd0, bus.s_awready}, 32'd0);
    chk("t2_blocked_valid", {31'd0, bus.m_awvalid}, 32'd0);
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    #1;
    chk("t2_after_b_ready", {31'd0, bus.s_awready}, 32'd1);
    tick();
    chk("t2_refill_ready", {31'd0, bus.s_awready}, 32'd0);
    chk("t2_wr_cnt", {24'd0, dut.wr_cnt_r}, 32'd16);
    clear_inputs();

    // T3: beat budget per window, refill on wrap
    do_reset();
    cfg_enable = 1'b1;
    tick();
    acc = 0;
    for (int c = 1; c < 1100; c++) begin
      bus.s_arvalid = 1'b1; bus.s_arlen = 8'd127; bus.m_arready = 1'b1;
      #1;
      if (bus.s_arready && bus.m_arvalid) acc++;
      tick();
      if (c == 1000) begin
        chk("t3_first_window", acc, 32'd4);
        chk("t3_throttled", {31'd0, throttle_active}, 32'd1);
        chk("t3_beats_zero", {16'd0, dut.beats_left_r}, 32'd0);
      end
      if (c == 1023) chk("t3_wrap_open", {31'd0, throttle_active}, 32'd0);
    end
    clear_inputs();
    chk("t3_second_window", acc, 32'd8);
    chk("t3_rethrottled", {31'd0, throttle_active}, 32'd1);

    // T6 then T5: stall statistics, underflow flag, async reset while throttled
    do_reset();
    cfg_enable = 1'b1;
    tick();
    for (int c = 0; c < 102; c++) begin
      bus.s_arvalid = 1'b1; bus.s_arlen = 8'd255; bus.m_arready = 1'b1;
      tick();
    end
    clear_inputs();
    chk("t6_stall_cycles", stall_cycles, EXP_STALL);
    chk("t5_err_before", {31'd0, err_underflow}, 32'd0);
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    chk("t5_err_set", {31'd0, err_underflow}, 32'd1);
    chk("t5_wr_zero", {24'd0, dut.wr_cnt_r}, 32'd0);
    tick();
    chk("t5_err_sticky", {31'd0, err_underflow}, 32'd1);
    chk("t5_throttle_pre", {31'd0, throttle_active}, 32'd1);
    #2;
    reset_rtl_0 = 1'b0;
    #1;
    chk("t5_async_throttle", {31'd0, throttle_active}, 32'd0);
    chk("t5_async_err", {31'd0, err_underflow}, 32'd0);
    chk("t5_async_stall", stall_cycles, 32'd0);
    chk("t5_async_beats", {16'd0, dut.beats_left_r}, 32'd512);
    reset_rtl_0 = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
